uart_tx_core: RTL and testbench

- Serial transmitter stage directly downstream of the TX-side controller FSM; consumes the parallel byte/valid pair and drives the UART line.
- Frames each accepted byte as start + 8 data bits (LSB first) + optional parity + stop.
- Provides the Busy handshake the controller uses to sequence multi-byte responses (ALU result low/high byte, register read byte).
- Clocked by the divided TX baud clock: one CLK period = one bit time.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_serializer.sv | 59 +++++
 rtl/uart_tx_core.sv | 117 +++++++++++
 tb/tb_uart_tx_core.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states and line levels.
package uart_pkg;

   // Transmitter frame phases, in the order they occur on the line.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Line levels for the framing bits.
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Parity type selector values.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// Holds the byte captured at frame accept and walks a bit index across it.
// The captured byte is never shifted, so the core can compute parity from it
// at any point in the frame.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load_i,
   input  logic                  shift_en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  bit_o,
   output logic                  next_bit_o,
   output logic                  last_o
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state: load captures the byte and rewinds the index; shift advances
   // the index but never past the last bit.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         data_d = data_i;
         cnt_d  = '0;
      end else if (shift_en_i && (cnt_q != CNT_LAST)) begin
         cnt_d = cnt_inc;
      end
   end

   // Capture register and bit index, cleared asynchronously.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_o     = data_q;
   assign bit_o      = data_q[cnt_q];
   // Only meaningful while not on the last bit; the wrapped index is harmless.
   assign next_bit_o = data_q[cnt_inc];
   assign last_o     = (cnt_q == CNT_LAST);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_core.sv
// UART transmitter: start + DATA_WIDTH data bits (LSB first) + optional
// parity + stop. One CLK period is one bit time. TX_OUT and Busy are
// registered and hold the level of the bit currently on the line.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   tx_state_e             state_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  par_en_q;
   logic                  par_typ_q;

   logic                  load;
   logic                  shift_en;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  cur_bit;
   logic                  next_bit;
   logic                  last_bit;
   logic                  parity_bit;

   // Inputs are only looked at in IDLE, so anything upstream does mid-frame
   // cannot disturb the frame in flight.
   assign load     = (state_q == ST_IDLE) && DATA_VALID;
   assign shift_en = (state_q == ST_DATA) && !last_bit;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .CLK        (CLK),
      .RST        (RST),
      .load_i     (load),
      .shift_en_i (shift_en),
      .data_i     (P_DATA),
      .data_o     (cap_data),
      .bit_o      (cur_bit),
      .next_bit_o (next_bit),
      .last_o     (last_bit)
   );

   // Parity from the captured byte; odd parity is the inverted XOR.
   assign parity_bit = (^cap_data) ^ (par_typ_q == PAR_ODD);

   // Frame sequencer. Each branch loads TX_OUT with the level of the bit that
   // the next state puts on the line, keeping the output glitch-free.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         tx_q      <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q   <= IDLE_LEVEL;
               busy_q <= 1'b0;
               if (DATA_VALID) begin
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  state_q   <= ST_START;
                  tx_q      <= START_BIT;
                  busy_q    <= 1'b1;
               end
            end
            ST_START: begin
               // Index was rewound on accept, so cur_bit is data bit 0.
               state_q <= ST_DATA;
               tx_q    <= cur_bit;
            end
            ST_DATA: begin
               if (last_bit) begin
                  if (par_en_q) begin
                     state_q <= ST_PARITY;
                     tx_q    <= parity_bit;
                  end else begin
                     state_q <= ST_STOP;
                     tx_q    <= STOP_BIT;
                  end
               end else begin
                  tx_q <= next_bit;
               end
            end
            ST_PARITY: begin
               state_q <= ST_STOP;
               tx_q    <= STOP_BIT;
            end
            ST_STOP: begin
               // Always pass through IDLE so Busy drops for at least a cycle.
               state_q <= ST_IDLE;
               tx_q    <= IDLE_LEVEL;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= IDLE_LEVEL;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frames plus randomized frames,
// compared against a frame model built from the bit-level framing rules.
module tb_uart_tx_core;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       DATA_VALID = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       TX_OUT;
   logic       Busy;

   int total = 0;
   int bad   = 0;

   logic exp_q[$];

   uart_tx_core #(
      .DATA_WIDTH (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic obs, input logic expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, expv, $time);
      end
   endtask

   // Line levels of one whole frame, one entry per bit time.
   function automatic void model_frame(input logic [7:0] d, input logic pe, input logic pt);
      int ones;
      exp_q = {};
      exp_q.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pe) exp_q.push_back(((ones % 2) == 1) ^ pt);
      exp_q.push_back(1'b1);
   endfunction

   task automatic idle_cycles(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check($sformatf("%s idle%0d tx", name, i), TX_OUT, 1'b1);
         check($sformatf("%s idle%0d busy", name, i), Busy, 1'b0);
      end
   endtask

   // Called at a negedge with the DUT in IDLE (from_stop=0) or in its STOP
   // cycle (from_stop=1). mode: 0 pulse valid, 1 scramble inputs mid-frame,
   // 2 directed mid-frame change, 3 hold valid high through the frame.
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input int from_stop, input int mode, input string name);
      int n;
      model_frame(d, pe, pt);
      n = exp_q.size();
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      DATA_VALID = 1'b1;
      if (from_stop != 0) begin
         @(negedge CLK);
         check({name, " gap busy"}, Busy, 1'b0);
         check({name, " gap tx"}, TX_OUT, 1'b1);
      end
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         check($sformatf("%s bit%0d tx", name, k), TX_OUT, exp_q[k]);
         check($sformatf("%s bit%0d busy", name, k), Busy, 1'b1);
         if (k == n - 1) begin
            DATA_VALID = 1'b0;
         end else if (mode == 0) begin
            DATA_VALID = 1'b0;
         end else if (mode == 1) begin
            P_DATA     = 8'($urandom);
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
            DATA_VALID = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            P_DATA     = 8'hF0;
            PAR_EN     = 1'b1;
            PAR_TYP    = ~pt;
            DATA_VALID = k[0];
         end
      end
      $display("frame %s data=%02h par_en=%0b par_typ=%0b bits=%0d mode=%0d",
               name, d, pe, pt, n, mode);
   endtask

   initial begin
      int chained;
      int m;
      logic [7:0] rd;
      logic rpe, rpt;

      // Reset state
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset tx", TX_OUT, 1'b1);
      check("reset busy", Busy, 1'b0);
      RST = 1'b1;
      idle_cycles(2, "post_reset");

      // Basic frames, with and without parity
      send_frame(8'hA5, 1'b0, 1'b0, 0, 0, "a5_nopar");
      idle_cycles(2, "a5_nopar");
      send_frame(8'hA5, 1'b1, 1'b0, 0, 0, "a5_even");
      idle_cycles(1, "a5_even");
      send_frame(8'hA5, 1'b1, 1'b1, 0, 0, "a5_odd");
      idle_cycles(1, "a5_odd");
      send_frame(8'h01, 1'b1, 1'b1, 0, 0, "01_odd");
      idle_cycles(1, "01_odd");

      // Valid held high: back-to-back frames with a one-cycle gap
      send_frame(8'h3C, 1'b0, 1'b0, 0, 3, "hold_3c");
      send_frame(8'hC3, 1'b0, 1'b0, 1, 0, "hold_c3");
      idle_cycles(2, "hold_c3");

      // Mid-frame input changes must not affect the frame
      send_frame(8'h0F, 1'b0, 1'b0, 0, 2, "mut_0f");
      idle_cycles(3, "mut_0f");

      // Asynchronous reset during data bit 3
      model_frame(8'h55, 1'b0, 1'b0);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         @(negedge CLK);
         check($sformatf("rst55 bit%0d tx", k), TX_OUT, exp_q[k]);
         check($sformatf("rst55 bit%0d busy", k), Busy, 1'b1);
         DATA_VALID = 1'b0;
      end
      #2 RST = 1'b0;
      #1;
      check("rst55 async tx", TX_OUT, 1'b1);
      check("rst55 async busy", Busy, 1'b0);
      $display("reset asserted mid-frame at t=%0t", $time);
      @(negedge CLK);
      RST = 1'b1;
      idle_cycles(4, "rst55_release");
      send_frame(8'h55, 1'b0, 1'b0, 0, 0, "after_rst55");
      idle_cycles(1, "after_rst55");

      // Valid toggled while busy: nothing queued
      send_frame(8'h96, 1'b1, 1'b0, 0, 1, "toggle");
      idle_cycles(3, "toggle");

      // Randomized frames, some chained back-to-back
      chained = 0;
      for (int it = 0; it < 40; it++) begin
         rd  = 8'($urandom);
         rpe = 1'($urandom_range(0, 1));
         rpt = 1'($urandom_range(0, 1));
         m   = (it == 39) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
         send_frame(rd, rpe, rpt, chained, m, $sformatf("rand%0d", it));
         chained = (m == 3) ? 1 : 0;
         if (chained == 0) idle_cycles(int'($urandom_range(1, 3)), $sformatf("rand%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_tx_core
